// File: rtl/booth_sequencer_if.sv
// Operand and result handshakes of the Booth sequencer.
// The master side supplies operand pairs and consumes results.
// The slave side is the sequencer itself.
interface booth_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                      op_valid;
  logic                      op_ready;
  logic signed [WIDTH-1:0]   op_m;
  logic signed [WIDTH-1:0]   op_q;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [2*WIDTH-1:0] res_product;
  logic                      res_timeout;

  modport master (
    output op_valid, op_m, op_q, res_ready,
    input  op_ready, res_valid, res_product, res_timeout
  );

  modport slave (
    input  op_valid, op_m, op_q, res_ready,
    output op_ready, res_valid, res_product, res_timeout
  );
endinterface

// File: rtl/booth_sequencer.sv
// Control stage around the byte-serial Booth multiplier core.
// It takes one signed operand pair, issues beginsig, then loads M and Q over inbus
// with locksig. It waits for endsig and rebuilds the product from two outbus bytes,
// hi byte first. A watchdog turns a core that never raises endsig into a timeout
// result.
// TIMEOUT must be at least 1.
module booth_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_sequencer_if.slave     bus,
  output logic                 beginsig,
  output logic                 locksig,
  output logic [WIDTH-1:0]     inbus,
  input  logic [WIDTH-1:0]     outbus,
  input  logic                 endsig
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_LOAD_M,
    S_LOAD_Q,
    S_WAIT,
    S_CAP_LO,
    S_HOLD
  } state_t;

  state_t                  state;
  logic [WD_W-1:0]         wd;
  logic signed [WIDTH-1:0] m_reg;
  logic signed [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0]        hi_byte;

  // Operand and hi-byte holding registers; they carry data only, so they have no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.op_valid && bus.op_ready) begin
      m_reg <= bus.op_m;
      q_reg <= bus.op_q;
    end
    if (state == S_WAIT && endsig) begin
      hi_byte <= outbus;
    end
  end

  // Sequencer FSM with registered core strobes, handshake outputs and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      wd              <= '0;
      bus.op_ready    <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_product <= '0;
      bus.res_timeout <= 1'b0;
      beginsig        <= 1'b0;
      locksig         <= 1'b0;
      inbus           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.op_valid && bus.op_ready) begin
            bus.op_ready <= 1'b0;
            beginsig     <= 1'b1;
            state        <= S_BEGIN;
          end else begin
            // op_ready comes up one cycle after reset release.
            bus.op_ready <= 1'b1;
          end
        end
        S_BEGIN: begin
          beginsig <= 1'b0;
          locksig  <= 1'b1;
          inbus    <= m_reg;
          state    <= S_LOAD_M;
        end
        S_LOAD_M: begin
          inbus <= q_reg;
          state <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          // inbus keeps Q through WAIT.
          locksig <= 1'b0;
          wd      <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // endsig takes priority over the watchdog on its final cycle.
          if (endsig) begin
            state <= S_CAP_LO;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            bus.res_product <= '0;
            bus.res_timeout <= 1'b1;
            bus.res_valid   <= 1'b1;
            state           <= S_HOLD;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CAP_LO: begin
          bus.res_product <= {hi_byte, outbus};
          bus.res_timeout <= 1'b0;
          bus.res_valid   <= 1'b1;
          state           <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid   <= 1'b0;
            bus.res_timeout <= 1'b0;
            bus.op_ready    <= 1'b1;
            state           <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer.
// A core stand-in answers the command protocol with the true signed product of the
// bytes it was given. A scoreboard of expected results is filled when operations are
// issued and drained by a monitor that also drives res_ready backpressure.
module tb_booth_sequencer;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             beginsig, locksig, endsig;
  logic [WIDTH-1:0] inbus, outbus;

  booth_sequencer_if #(.WIDTH(WIDTH)) bus ();

  booth_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .beginsig(beginsig), .locksig(locksig), .inbus(inbus),
    .outbus(outbus), .endsig(endsig)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle counter used to measure handshake-to-result latency.
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef enum {M_NORMAL, M_EARLY, M_NEVER} mode_t;
  typedef struct {
    mode_t      mode;
    int         delay;
    bit         spur;
    logic [7:0] m;
    logic [7:0] q;
  } cfg_t;
  typedef struct {
    logic [15:0] product;
    bit          timeout;
    int          lat;
    int          bp;
  } exp_t;

  cfg_t cfg_q[$];
  exp_t exp_q[$];
  int   hs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[15:0];
  endfunction

  // Issues one operation: arms the core stand-in, records the expected result, and
  // performs the op handshake.
  task automatic issue(input logic [7:0] m, input logic [7:0] q, input mode_t mode,
                       input int delay, input bit spur, input int bp, input bit expect_res);
    cfg_t c;
    exp_t e;
    int   n;
    c.mode = mode; c.delay = delay; c.spur = spur; c.m = m; c.q = q;
    cfg_q.push_back(c);
    if (expect_res) begin
      e.bp = bp;
      if (mode == M_NEVER) begin
        e.product = 16'h0000; e.timeout = 1'b1; e.lat = 3 + TIMEOUT;
      end else begin
        e.product = ref_product(m, q); e.timeout = 1'b0;
        e.lat = (mode == M_EARLY) ? 5 : 4 + delay;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_m = m; bus.op_q = q;
    n = 0;
    while (!bus.op_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) begin
      total++; bad++;
      $display("FAIL op_handshake: op_ready still %0b after %0d cycles, want 1", bus.op_ready, n);
      bus.op_valid = 1'b0;
      return;
    end
    if (expect_res) hs_q.push_back(cyc + 1);
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // Core stand-in: latches M and Q from the locksig cycles, then returns the product
  // bytes hi-then-lo.
  initial begin : core_model
    cfg_t        c;
    logic [7:0]  cm, cq;
    logic [15:0] p;
    endsig = 1'b0;
    outbus = '0;
    forever begin
      @(negedge clk);
      if (rst_n && beginsig) begin
        if (cfg_q.size() > 0) begin
          c = cfg_q.pop_front();
        end else begin
          c.mode = M_NEVER; c.delay = 0; c.spur = 1'b0; c.m = '0; c.q = '0;
        end
        endsig = c.spur;
        outbus = c.spur ? 8'($urandom) : 8'h00;
        @(negedge clk);  // LOAD_M
        check("beginsig_one_cycle", beginsig, 1'b0);
        check("locksig_load_m", locksig, 1'b1);
        check("inbus_m", inbus, c.m);
        cm = inbus;
        @(negedge clk);  // LOAD_Q
        check("locksig_load_q", locksig, 1'b1);
        check("inbus_q", inbus, c.q);
        cq = inbus;
        p = ref_product(cm, cq);
        if (c.mode == M_EARLY) begin
          endsig = 1'b1; outbus = p[15:8];
        end
        @(negedge clk);  // first WAIT cycle
        check("locksig_wait", locksig, 1'b0);
        check("inbus_hold_q", inbus, c.q);
        case (c.mode)
          M_EARLY: begin
            @(negedge clk);
            endsig = 1'b0; outbus = p[7:0];
            @(negedge clk);
            outbus = '0;
          end
          M_NEVER: begin
            endsig = 1'b0; outbus = '0;
          end
          default: begin
            endsig = 1'b0; outbus = '0;
            for (int i = 1; i < c.delay; i++) @(negedge clk);
            endsig = 1'b1; outbus = p[15:8];
            @(negedge clk);
            endsig = 1'b0; outbus = p[7:0];
            @(negedge clk);
            outbus = '0;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each new result, applies backpressure and checks
  // hold stability and the return to IDLE.
  initial begin : monitor
    exp_t e;
    int   hs;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.res_ready = 1'b0;
      end else if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: res_valid=1 product=%0h with nothing outstanding",
                   $unsigned(bus.res_product));
          bus.res_ready = 1'b1;
        end else begin
          e  = exp_q.pop_front();
          hs = (hs_q.size() > 0) ? hs_q.pop_front() : cyc;
          check("res_product", $unsigned(bus.res_product), e.product);
          check("res_timeout", bus.res_timeout, e.timeout);
          check("latency", cyc - hs, e.lat);
          check("op_ready_in_hold", bus.op_ready, 1'b0);
          for (int i = 0; i < e.bp; i++) begin
            bus.res_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", bus.res_valid, 1'b1);
            check("hold_product", $unsigned(bus.res_product), e.product);
            check("hold_timeout", bus.res_timeout, e.timeout);
            check("hold_op_ready", bus.op_ready, 1'b0);
          end
          bus.res_ready = 1'b1;
          @(negedge clk);
          check("accept_valid_low", bus.res_valid, 1'b0);
          check("accept_timeout_low", bus.res_timeout, 1'b0);
          check("accept_op_ready", bus.op_ready, 1'b1);
          bus.res_ready = (exp_q.size() > 0 && exp_q[0].bp == 0);
        end
      end else begin
        bus.res_ready = (exp_q.size() > 0 && exp_q[0].bp == 0);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.res_valid) begin
      total++; bad++;
      $display("FAIL drain: %0d results still outstanding, want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Main stimulus sequence.
  initial begin : stimulus
    int    r;
    mode_t md;
    bus.op_valid = 1'b0; bus.op_m = '0; bus.op_q = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", bus.op_ready, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_product", $unsigned(bus.res_product), 16'h0000);
    check("rst_res_timeout", bus.res_timeout, 1'b0);
    check("rst_beginsig", beginsig, 1'b0);
    check("rst_locksig", locksig, 1'b0);
    check("rst_inbus", inbus, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("op_ready_after_reset", bus.op_ready, 1'b1);

    issue(8'h45, 8'hD3, M_NORMAL, 10, 1'b0, 0, 1'b1);
    issue(8'h80, 8'h80, M_NORMAL, 3, 1'b0, 0, 1'b1);
    issue(8'h7F, 8'hFF, M_NORMAL, 1, 1'b0, 0, 1'b1);
    issue(8'h5A, 8'hA7, M_NORMAL, 5, 1'b0, 20, 1'b1);
    issue(8'h12, 8'h34, M_NEVER, 0, 1'b0, 0, 1'b1);
    issue(8'h05, 8'hFA, M_NORMAL, 2, 1'b0, 0, 1'b1);
    issue(8'h9C, 8'h3B, M_NORMAL, 4, 1'b1, 0, 1'b1);
    issue(8'hC8, 8'h07, M_EARLY, 0, 1'b0, 0, 1'b1);
    issue(8'h01, 8'h80, M_NORMAL, 12, 1'b1, 2, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      md = (r == 0) ? M_EARLY : (r == 1) ? M_NEVER : M_NORMAL;
      issue(8'($urandom), 8'($urandom), md, $urandom_range(1, 12),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b1);
    end
    drain();

    // Abort in WAIT: nothing from this operation may ever come out.
    issue(8'h33, 8'h44, M_NEVER, 0, 1'b0, 0, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_op_ready", bus.op_ready, 1'b0);
    check("abort_res_valid", bus.res_valid, 1'b0);
    check("abort_res_product", $unsigned(bus.res_product), 16'h0000);
    check("abort_res_timeout", bus.res_timeout, 1'b0);
    check("abort_beginsig", beginsig, 1'b0);
    check("abort_locksig", locksig, 1'b0);
    check("abort_inbus", inbus, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_op_ready_after", bus.op_ready, 1'b1);
    repeat (TIMEOUT + 10) @(negedge clk);
    check("abort_no_result", bus.res_valid, 1'b0);

    issue(8'hE0, 8'h10, M_NORMAL, 6, 1'b0, 1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
